// File: rtl/pregame_pkg.sv
// Shared definitions for the pre-game sequencer and the in-game controller:
// scene state encoding and the player-count clamp.
package pregame_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_DELAY    = 3'd2,
    S_REQ_NAME = 3'd3,
    S_END      = 3'd4,
    S_DONE     = 3'd5,
    S_ERROR    = 3'd6
  } state_t;

  // A request of zero players still runs one name entry.
  function automatic int clamp_players(input int requested, input int max_players);
    if (requested < 1) return 1;
    if (requested > max_players) return max_players;
    return requested;
  endfunction

endpackage

// File: rtl/pregame_timer.sv
// Loadable up-counter with terminal-count compare; holds at the terminal
// value so it never wraps.
module pregame_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign at_term = (count_q == term);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (inc && !at_term) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pregame_sequencer.sv
// Pre-game sequencer: clears MODEL, collects one user name per player from
// VIEW with a settle delay before each request, then waits for end confirm.
module pregame_sequencer
  import pregame_pkg::*;
#(
  parameter int MAX_PLAYERS   = 2,
  parameter int DELAY_CYCLES  = 1000,
  parameter int RESET_TIMEOUT = 1023,
  parameter int PW            = $clog2(MAX_PLAYERS + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] num_players,
  input  logic          mode_coop,
  input  logic          cbk_for_reset,
  input  logic          cbk_for_view,
  input  logic          cbk_for_end_confirm,
  output logic          clear_req,
  output logic          user_name_req,
  output logic [PW-1:0] user_name_idx,
  output logic [PW-1:0] players_lat,
  output logic          coop_lat,
  output logic          end_req,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int TMAX = (DELAY_CYCLES > RESET_TIMEOUT) ? DELAY_CYCLES : RESET_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DELAY_TERM   = TW'(DELAY_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_TERM = TW'(RESET_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [PW-1:0] players_q, players_d;
  logic          coop_q, coop_d;
  logic          clear_req_q, clear_req_d;
  logic          name_req_q, name_req_d;
  logic [PW-1:0] name_idx_q, name_idx_d;
  logic          end_req_q, end_req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          timer_load;
  logic          timer_inc;
  logic          timer_at_term;
  logic [TW-1:0] timer_term;

  // Delay and timeout never run together, so one counter serves both.
  assign timer_term = (state_q == S_CLEAR) ? TIMEOUT_TERM : DELAY_TERM;

  pregame_timer #(.W(TW)) u_timer (
    .clock   (clock),
    .resetn  (resetn),
    .load    (timer_load),
    .inc     (timer_inc),
    .term    (timer_term),
    .at_term (timer_at_term)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    players_d  = players_q;
    coop_d     = coop_q;
    timer_load = 1'b0;
    timer_inc  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state_d    = S_CLEAR;
            players_d  = PW'(clamp_players(int'(num_players), MAX_PLAYERS));
            coop_d     = mode_coop;
            idx_d      = '0;
            timer_load = 1'b1;
          end
        end
        S_CLEAR: begin
          // An ack arriving on the timeout edge still counts as success.
          if (cbk_for_reset) begin
            state_d    = S_DELAY;
            timer_load = 1'b1;
          end else if (timer_at_term) begin
            state_d = S_ERROR;
          end else begin
            timer_inc = 1'b1;
          end
        end
        S_DELAY: begin
          if (timer_at_term) begin
            state_d = S_REQ_NAME;
          end else begin
            timer_inc = 1'b1;
          end
        end
        S_REQ_NAME: begin
          if (cbk_for_view) begin
            if (idx_q == (players_q - PW'(1))) begin
              state_d = S_END;
            end else begin
              state_d    = S_DELAY;
              idx_d      = idx_q + PW'(1);
              timer_load = 1'b1;
            end
          end
        end
        S_END: begin
          if (cbk_for_end_confirm) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    clear_req_d = (state_d == S_CLEAR);
    name_req_d  = (state_d == S_REQ_NAME);
    name_idx_d  = (state_d == S_REQ_NAME) ? idx_d : '0;
    end_req_d   = (state_d == S_END);
    busy_d      = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      players_q   <= '0;
      coop_q      <= 1'b0;
      clear_req_q <= 1'b0;
      name_req_q  <= 1'b0;
      name_idx_q  <= '0;
      end_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      players_q   <= players_d;
      coop_q      <= coop_d;
      clear_req_q <= clear_req_d;
      name_req_q  <= name_req_d;
      name_idx_q  <= name_idx_d;
      end_req_q   <= end_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign clear_req     = clear_req_q;
  assign user_name_req = name_req_q;
  assign user_name_idx = name_idx_q;
  assign players_lat   = players_q;
  assign coop_lat      = coop_q;
  assign end_req       = end_req_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_pregame_sequencer.sv
// Self-checking bench for pregame_sequencer: a vector table for one full
// two-player session plus directed sequences for timeout, abort and reset.
module tb_pregame_sequencer;

  localparam int MAXP = 4;
  localparam int DLY  = 4;
  localparam int RTO  = 8;
  localparam int PW   = 3;

  logic          clock = 1'b0;
  logic          resetn;
  logic          start;
  logic          abort;
  logic [PW-1:0] num_players;
  logic          mode_coop;
  logic          cbk_for_reset;
  logic          cbk_for_view;
  logic          cbk_for_end_confirm;
  logic          clear_req;
  logic          user_name_req;
  logic [PW-1:0] user_name_idx;
  logic [PW-1:0] players_lat;
  logic          coop_lat;
  logic          end_req;
  logic          busy;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;

  pregame_sequencer #(
    .MAX_PLAYERS   (MAXP),
    .DELAY_CYCLES  (DLY),
    .RESET_TIMEOUT (RTO)
  ) dut (
    .clock               (clock),
    .resetn              (resetn),
    .start               (start),
    .abort               (abort),
    .num_players         (num_players),
    .mode_coop           (mode_coop),
    .cbk_for_reset       (cbk_for_reset),
    .cbk_for_view        (cbk_for_view),
    .cbk_for_end_confirm (cbk_for_end_confirm),
    .clear_req           (clear_req),
    .user_name_req       (user_name_req),
    .user_name_idx       (user_name_idx),
    .players_lat         (players_lat),
    .coop_lat            (coop_lat),
    .end_req             (end_req),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int start, abort, num, coop, ack_reset, ack_view, ack_end;
    int e_clear, e_req, e_idx, e_end, e_busy, e_done, e_error, e_players, e_coop;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic flagTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    start               = 1'(v.start);
    abort               = 1'(v.abort);
    num_players         = PW'(v.num);
    mode_coop           = 1'(v.coop);
    cbk_for_reset       = 1'(v.ack_reset);
    cbk_for_view        = 1'(v.ack_view);
    cbk_for_end_confirm = 1'(v.ack_end);
    tick();
  endtask

  task automatic checkVector(input int n, input vec_t v);
    checkOutput($sformatf("v%0d_clear", n),   clear_req,     v.e_clear);
    checkOutput($sformatf("v%0d_req", n),     user_name_req, v.e_req);
    checkOutput($sformatf("v%0d_idx", n),     user_name_idx, v.e_idx);
    checkOutput($sformatf("v%0d_end", n),     end_req,       v.e_end);
    checkOutput($sformatf("v%0d_busy", n),    busy,          v.e_busy);
    checkOutput($sformatf("v%0d_done", n),    done,          v.e_done);
    checkOutput($sformatf("v%0d_error", n),   error,         v.e_error);
    checkOutput($sformatf("v%0d_players", n), players_lat,   v.e_players);
    checkOutput($sformatf("v%0d_coop", n),    coop_lat,      v.e_coop);
  endtask

  // All acks held high: every request lasts one cycle and must still be
  // preceded by exactly DLY delay cycles.
  task automatic runSession(input int num, input int coop, input int exp_players);
    int reqs = 0;
    int gap = 0;
    bit finished = 1'b0;
    start = 1'b1;
    num_players = PW'(num);
    mode_coop = 1'(coop);
    cbk_for_reset = 1'b1;
    cbk_for_view = 1'b1;
    cbk_for_end_confirm = 1'b1;
    tick();
    checkOutput("sess_start_clear", clear_req, 1);
    checkOutput("sess_players", players_lat, exp_players);
    checkOutput("sess_coop", coop_lat, coop);
    start = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      tick();
      if (user_name_req) begin
        checkOutput("sess_idx", user_name_idx, reqs);
        checkOutput("sess_gap", gap, DLY);
        reqs++;
        gap = 0;
      end else if (busy && !clear_req && !end_req) begin
        gap++;
      end
      if (done) finished = 1'b1;
    end
    if (!finished) flagTimeout("sess_done_wait");
    tick();
    checkOutput("sess_done_pulse", done, 0);
    checkOutput("sess_busy_after", busy, 0);
    checkOutput("sess_reqs", reqs, exp_players);
    cbk_for_reset = 1'b0;
    cbk_for_view = 1'b0;
    cbk_for_end_confirm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    //          st ab num co ar av ae | clr req idx end bsy dn err pl coop
    vecs[0]  = '{1, 0, 2, 1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 2, 1};
    vecs[1]  = '{0, 0, 2, 1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0, 2, 1};
    vecs[2]  = '{0, 0, 2, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 2, 1};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 2, 1};
    vecs[4]  = '{1, 0, 4, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 2, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 2, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 0, 2, 1};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0, 0, 2, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 2, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 2, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 2, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0, 0, 2, 1};
    vecs[12] = '{0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 0, 1, 0, 0, 2, 1};
    vecs[13] = '{0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1, 0, 0, 2, 1};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 2, 1};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0, 2, 1};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 2, 1};
    vecs[17] = '{1, 1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2, 1};

    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    num_players = '0;
    mode_coop = 1'b0;
    cbk_for_reset = 1'b0;
    cbk_for_view = 1'b0;
    cbk_for_end_confirm = 1'b0;
    #1;
    checkOutput("rst_clear", clear_req, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_players", players_lat, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    $display("[TB] vector table: two-player session");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end
    start = 1'b0;
    abort = 1'b0;

    $display("[TB] sessions with held acks and player-count clamping");
    runSession(3, 0, 3);
    runSession(0, 1, 1);
    runSession(7, 0, 4);

    $display("[TB] reset timeout");
    start = 1'b1;
    num_players = PW'(1);
    tick();
    checkOutput("to_clear_rise", clear_req, 1);
    start = 1'b0;
    for (int i = 0; i < RTO - 1; i++) tick();
    checkOutput("to_pre_error", error, 0);
    checkOutput("to_pre_clear", clear_req, 1);
    tick();
    checkOutput("to_error", error, 1);
    checkOutput("to_error_clear", clear_req, 0);
    checkOutput("to_error_busy", busy, 0);
    start = 1'b1;
    tick();
    checkOutput("to_restart_clear", clear_req, 1);
    checkOutput("to_restart_error", error, 0);
    checkOutput("to_restart_busy", busy, 1);
    start = 1'b0;
    for (int i = 0; i < RTO - 1; i++) tick();
    cbk_for_reset = 1'b1;
    tick();
    checkOutput("ack_wins_error", error, 0);
    checkOutput("ack_wins_busy", busy, 1);
    checkOutput("ack_wins_clear", clear_req, 0);
    cbk_for_reset = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;

    $display("[TB] abort during second name request");
    start = 1'b1;
    num_players = PW'(3);
    mode_coop = 1'b0;
    cbk_for_reset = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      if (user_name_req && user_name_idx == PW'(1)) found = 1'b1;
      else cbk_for_view = user_name_req && (user_name_idx == PW'(0));
    end
    if (!found) flagTimeout("abort_wait_idx1");
    cbk_for_view = 1'b0;
    abort = 1'b1;
    tick();
    checkOutput("abort_clear", clear_req, 0);
    checkOutput("abort_req", user_name_req, 0);
    checkOutput("abort_idx", user_name_idx, 0);
    checkOutput("abort_end", end_req, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_error", error, 0);
    checkOutput("abort_players_hold", players_lat, 3);
    start = 1'b1;
    tick();
    checkOutput("abort_start_clear", clear_req, 0);
    checkOutput("abort_start_busy", busy, 0);
    abort = 1'b0;
    tick();
    checkOutput("restart_clear", clear_req, 1);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      tick();
      if (user_name_req) begin
        found = 1'b1;
        checkOutput("restart_idx", user_name_idx, 0);
      end
    end
    if (!found) flagTimeout("restart_wait_req");
    abort = 1'b1;
    tick();
    abort = 1'b0;

    $display("[TB] asynchronous reset during delay");
    start = 1'b1;
    num_players = PW'(2);
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("mid_delay_busy", busy, 1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_busy", busy, 0);
    checkOutput("async_players", players_lat, 0);
    checkOutput("async_clear", clear_req, 0);
    start = 1'b1;
    tick();
    checkOutput("rst_start_clear", clear_req, 0);
    checkOutput("rst_start_busy", busy, 0);
    #2;
    resetn = 1'b1;
    start = 1'b0;
    cbk_for_reset = 1'b0;
    tick();
    checkOutput("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pregame_sequencer.md
Name: pregame_sequencer

Overview:
Parametrised pre-game sequencer that runs before the game scene. On start, it issues a clear request to MODEL and waits for the reset callback, with a timeout. It then requests one user name per player (1..MAX_PLAYERS), separated by a settle delay, and waits for the VIEW end-confirm before reporting done. Sits between the top-level scene FSM and the MODEL/VIEW blocks.

Parameters:
MAX_PLAYERS, 2, maximum number of players (>=1)
DELAY_CYCLES, 1000, settle cycles before each name request (>=1)
RESET_TIMEOUT, 1023, cycles to wait for cbk_for_reset before error (>=1)
PW, $clog2(MAX_PLAYERS+1), width of the player count and index fields (derived; do not override)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  begin sequence (sampled in S_IDLE/S_ERROR)
abort  in  1  return to S_IDLE from any state
num_players  in  PW  requested player count; latched
mode_coop  in  1  0 = versus, 1 = cooperative; latched with num_players
cbk_for_reset  in  1  MODEL clear complete (level)
cbk_for_view  in  1  VIEW name entry complete (level)
cbk_for_end_confirm  in  1  VIEW end screen confirmed (level)
clear_req  out  1  clear data request to MODEL
user_name_req  out  1  name request valid
user_name_idx  out  PW  player index being requested, 0-based
players_lat  out  PW  latched, clamped player count
coop_lat  out  1  latched mode_coop
end_req  out  1  request VIEW end-of-pregame screen
busy  out  1  high in all states except S_IDLE, S_DONE and S_ERROR
done  out  1  one-cycle pulse on entering S_DONE
error  out  1  high while in S_ERROR

Behaviour:
- Reset (async assert, sync deassert handled upstream): state S_IDLE; all outputs 0; counters and latches 0.
- Outputs are registered Moore decodes of the state register. done is a one-cycle pulse.
- States:
  - S_IDLE: start=1 -> S_CLEAR. On this transition, latch num_players (0 is clamped to 1; >MAX_PLAYERS is clamped to MAX_PLAYERS) and mode_coop. Clear idx and the timer.
  - S_CLEAR: clear_req=1.
    - cbk_for_reset=1 at an edge -> S_DELAY and reload the timer.
    - Otherwise the timer increments. At timer == RESET_TIMEOUT-1 without ack -> S_ERROR.
    - Ack on the same edge as the timeout: ack wins.
  - S_DELAY: count DELAY_CYCLES cycles, then -> S_REQ_NAME. Delay runs from entry, so a stale cbk_for_view from the previous player is ignored.
  - S_REQ_NAME: user_name_req=1, user_name_idx=idx.
    - Stays until cbk_for_view=1.
    - Then: if idx == players_lat-1 -> S_END; else idx+1 -> S_DELAY.
  - S_END: end_req=1 until cbk_for_end_confirm=1 -> S_DONE.
  - S_DONE: done pulse for one cycle, then -> S_IDLE. Latches hold their values until the next start.
  - S_ERROR: error=1. start=1 -> S_CLEAR (re-latch as in S_IDLE). Held otherwise.
- abort=1 has the highest priority: from any state -> S_IDLE next edge; outputs deassert; latches hold. abort and start together in S_IDLE: stay in S_IDLE.
- start while busy is ignored.
- Latency from start to clear_req: 1 cycle. From cbk_for_reset to the first user_name_req: DELAY_CYCLES+1 cycles.
- Counters: delay/timeout timer width is $clog2(max(DELAY_CYCLES,RESET_TIMEOUT)+1). No wrap is possible because the count stops at its terminal value.
- idx never exceeds players_lat-1.

Decomposition:
- Shared package pregame_pkg: state encoding localparams (S_IDLE..S_ERROR, 3 bits) and a clamp function for player count, reused by the in-game controller.
- One sub-module, pregame_timer: loadable up-counter with terminal-count compare, shared by the delay and timeout uses (mutually exclusive states).

Test Plan:
1. MAX_PLAYERS=4, DELAY_CYCLES=4, num_players=3, immediate acks -> clear_req 1 cycle after start; user_name_req with idx 0,1,2, each preceded by 4 idle cycles; end_req; done pulse once; busy low after.
2. num_players=0, then separately num_players=7 (MAX=4) -> players_lat=1 with one name request; players_lat=4 with idx 0..3.
3. RESET_TIMEOUT=8, cbk_for_reset held 0 -> error=1 exactly 8 cycles after clear_req rose. Then start=1 -> S_CLEAR, clear_req=1, error=0. Variant with ack on the timeout edge -> no error.
4. abort asserted in S_REQ_NAME at idx=1 -> next cycle all outputs 0, busy=0; a new start restarts at idx=0 with clear_req.
5. cbk_for_view held 1 continuously -> each request is still separated by DELAY_CYCLES; exactly players_lat requests occur.
6. resetn pulsed low mid-S_DELAY (asynchronously, between edges) -> outputs 0 immediately; start ignored while resetn=0.
